// File: rtl/mips_pkg.sv
// Types and constants shared by the instruction memory loader and its RAM.
package mips_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } imem_state_t;

  localparam logic [31:0] NOP         = 32'b0;
  localparam int          WORD_OFFSET = 2;
endpackage

// File: rtl/imem_ram.sv
// Instruction storage: DEPTH x DATA_W, single write port, registered read port.
// Latency: read data appears the cycle after re; writes land on the clock edge.
// Backpressure: none, always accepts; contents survive reset.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program word-stream into instruction RAM, then serves PC-addressed fetches.
// Latency: fetch result (word + fault flags) one cycle after acceptance; load_done one cycle after final word.
// Backpressure: load_ready only while loading, fetch_ready only while running.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  output logic                     load_done,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        PC,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [DATA_W-1:0]        instruction,
  output logic                     fault_misalign,
  output logic                     fault_range,
  output logic [$clog2(DEPTH):0]   prog_len
);

  localparam int AW = $clog2(DEPTH);

  imem_state_t       state;
  logic [AW-1:0]     wr_ptr;
  logic              wr_en;
  logic              load_complete;
  logic              fetch_acc;
  logic [AW-1:0]     fetch_idx;
  logic              misalign_c;
  logic              range_c;
  logic [DATA_W-1:0] ram_rdata;

  assign load_ready    = (state == LOAD);
  assign fetch_ready   = (state == RUN);
  // A restart in the same cycle wins over any word on the bus.
  assign wr_en         = load_ready && load_valid && !load_start;
  assign load_complete = wr_en && (load_last || wr_ptr == AW'(DEPTH - 1));
  assign fetch_acc     = fetch_req && fetch_ready;

  assign fetch_idx  = PC[AW+WORD_OFFSET-1:WORD_OFFSET];
  assign misalign_c = (PC[WORD_OFFSET-1:0] != '0);
  assign range_c    = ((PC >> (AW + WORD_OFFSET)) != '0) || ({1'b0, fetch_idx} >= prog_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= EMPTY;
      wr_ptr         <= '0;
      prog_len       <= '0;
      load_done      <= 1'b0;
      fetch_valid    <= 1'b0;
      fault_misalign <= 1'b0;
      fault_range    <= 1'b0;
    end else begin
      load_done      <= 1'b0;
      fetch_valid    <= fetch_acc;
      fault_misalign <= fetch_acc && misalign_c;
      fault_range    <= fetch_acc && range_c;
      case (state)
        EMPTY, RUN: begin
          if (load_start) begin
            state  <= LOAD;
            wr_ptr <= '0;
          end
        end
        LOAD: begin
          if (load_start) begin
            wr_ptr <= '0;
          end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (load_complete) begin
              state     <= RUN;
              load_done <= 1'b1;
              prog_len  <= {1'b0, wr_ptr} + 1'b1;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  imem_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(load_data),
    .re   (fetch_acc),
    .raddr(fetch_idx),
    .rdata(ram_rdata)
  );

  // Faulted or idle cycles present a NOP rather than stale RAM output.
  assign instruction = (fetch_valid && !fault_misalign && !fault_range) ? ram_rdata : DATA_W'(NOP);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed + randomized bench for instr_mem_loader against a word-array program model.
module tb_instr_mem_loader;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_start = 1'b0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_last = 1'b0;
  logic              load_ready;
  logic              load_done;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] PC = '0;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [DATA_W-1:0] instruction;
  logic              fault_misalign;
  logic              fault_range;
  logic [LW-1:0]     prog_len;

  instr_mem_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .fetch_req(fetch_req), .PC(PC), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .instruction(instruction),
    .fault_misalign(fault_misalign), .fault_range(fault_range), .prog_len(prog_len)
  );

  always #5 clk = ~clk;

  // Program model: what has been written, and how long the last completed program is.
  logic [DATA_W-1:0] model_mem [DEPTH];
  int unsigned       model_len = 0;
  logic [DATA_W-1:0] stim [DEPTH];
  logic [ADDR_W-1:0] pcs [$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("load_ready_in_load", 64'(load_ready), 64'd1);
    chk("fetch_ready_in_load", 64'(fetch_ready), 64'd0);
  endtask

  // Feed stim[0..n-1]; when 'completes' the caller checks the done pulse after the last word.
  task automatic feed(input int n, input bit use_last, input bit completes);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load_valid = 1'b0;
        tick();
        chk("load_done_idle", 64'(load_done), 64'd0);
      end
      load_valid = 1'b1;
      load_data  = stim[i];
      load_last  = use_last && (i == n - 1);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      model_mem[i] = stim[i];
      if (!(completes && i == n - 1))
        chk("load_done_mid", 64'(load_done), 64'd0);
    end
  endtask

  task automatic finish_check(input int n);
    chk("load_done_pulse", 64'(load_done), 64'd1);
    chk("prog_len", 64'(prog_len), 64'(n));
    model_len = n;
    tick();
    chk("load_done_once", 64'(load_done), 64'd0);
    chk("load_ready_run", 64'(load_ready), 64'd0);
    chk("fetch_ready_run", 64'(fetch_ready), 64'd1);
  endtask

  // Back-to-back fetches of every PC in pcs, then one idle cycle.
  task automatic run_fetches();
    logic [31:0] idx;
    bit mis, rng;
    logic [DATA_W-1:0] exp_ins;
    for (int i = 0; i < pcs.size(); i++) begin
      chk("fetch_ready_pre", 64'(fetch_ready), 64'd1);
      fetch_req = 1'b1;
      PC = pcs[i];
      tick();
      idx = pcs[i] / 4;
      mis = (pcs[i] % 4) != 0;
      rng = idx >= model_len;
      exp_ins = (mis || rng) ? '0 : model_mem[idx];
      chk("fetch_valid", 64'(fetch_valid), 64'd1);
      chk("fault_misalign", 64'(fault_misalign), 64'(mis));
      chk("fault_range", 64'(fault_range), 64'(rng));
      chk("instruction", 64'(instruction), 64'(exp_ins));
    end
    fetch_req = 1'b0;
    tick();
    chk("fetch_valid_idle", 64'(fetch_valid), 64'd0);
    chk("instruction_idle", 64'(instruction), 64'd0);
    pcs.delete();
  endtask

  initial begin
    // Reset state
    tick();
    #1;
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_fetch_ready", 64'(fetch_ready), 64'd0);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_instruction", 64'(instruction), 64'd0);
    chk("rst_faults", 64'({fault_misalign, fault_range}), 64'd0);
    chk("rst_prog_len", 64'(prog_len), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("empty_load_ready", 64'(load_ready), 64'd0);

    // Six-word program with load_last on the final word
    stim[0] = 32'h20110001; stim[1] = 32'h20120002; stim[2] = 32'h20130003;
    stim[3] = 32'h20140004; stim[4] = 32'h20090002; stim[5] = 32'h20080003;
    start_load();
    feed(6, 1'b1, 1'b1);
    finish_check(6);

    pcs = '{32'd0, 32'd4, 32'd8};
    run_fetches();

    // Fault cases: misaligned, out of range, both, high PC bits
    pcs = '{32'd6, 32'd24, 32'd26, 32'd20, 32'h8000_0000, 32'h0000_0400};
    run_fetches();
    for (int i = 0; i < 12; i++) pcs.push_back(ADDR_W'($urandom_range(0, 40)));
    run_fetches();

    // Restart mid-load with a last-flagged word on the bus: that word must be dropped
    for (int i = 0; i < 5; i++) stim[i] = $urandom;
    start_load();
    feed(5, 1'b0, 1'b0);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_last  = 1'b1;
    load_data  = $urandom;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("restart_no_done", 64'(load_done), 64'd0);
    chk("restart_load_ready", 64'(load_ready), 64'd1);
    for (int i = 0; i < 3; i++) stim[i] = $urandom;
    feed(3, 1'b1, 1'b1);
    finish_check(3);
    pcs = '{32'd0, 32'd4, 32'd8, 32'd12};
    run_fetches();

    // Full-depth load with load_last never asserted
    for (int i = 0; i < DEPTH; i++) stim[i] = $urandom;
    start_load();
    feed(DEPTH, 1'b0, 1'b1);
    finish_check(DEPTH);
    pcs.push_back(ADDR_W'(4 * (DEPTH - 1)));
    pcs.push_back(ADDR_W'(4 * DEPTH));
    for (int i = 0; i < 20; i++) begin
      pcs.push_back(ADDR_W'($urandom_range(0, 4 * DEPTH + 64)));
      if ($urandom_range(0, 1) == 1) pcs[pcs.size() - 1][1:0] = 2'b00;
    end
    run_fetches();

    // Fetch and load_start in the same RUN cycle
    fetch_req  = 1'b1;
    PC         = 32'd4;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    PC         = 32'd8;
    chk("coll_fetch_valid", 64'(fetch_valid), 64'd1);
    chk("coll_instruction", 64'(instruction), 64'(model_mem[1]));
    chk("coll_faults", 64'({fault_misalign, fault_range}), 64'd0);
    chk("coll_load_ready", 64'(load_ready), 64'd1);
    chk("coll_fetch_ready", 64'(fetch_ready), 64'd0);
    tick();
    fetch_req = 1'b0;
    chk("coll_refused", 64'(fetch_valid), 64'd0);
    chk("coll_prog_len_kept", 64'(prog_len), 64'(model_len));

    // Reset in the middle of a load, after three words
    for (int i = 0; i < 3; i++) stim[i] = $urandom;
    start_load();
    feed(3, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    model_len = 0;
    chk("mid_rst_prog_len", 64'(prog_len), 64'd0);
    chk("mid_rst_load_ready", 64'(load_ready), 64'd0);
    chk("mid_rst_fetch_ready", 64'(fetch_ready), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_no_done", 64'(load_done), 64'd0);
      chk("post_rst_empty", 64'({load_ready, fetch_ready}), 64'd0);
      chk("post_rst_prog_len", 64'(prog_len), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter: DATA_W, default 32, instruction word width in bits.
REQ-002 Parameter: DEPTH, default 256, memory depth in words; power of two, at least 4.
REQ-003 Parameter: ADDR_W, default 32, PC width in bits.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: load_start  input  1  one-cycle pulse; begins a program load at word 0.
REQ-007 Port: load_valid  input  1  load_data holds a valid instruction word.
REQ-008 Port: load_data  input  DATA_W  instruction word to be written.
REQ-009 Port: load_last  input  1  marks the final word of the program.
REQ-010 Port: load_ready  output  1  block accepts a load word this cycle.
REQ-011 Port: load_done  output  1  one-cycle pulse when a load completes.
REQ-012 Port: fetch_req  input  1  fetch request at PC.
REQ-013 Port: PC  input  ADDR_W  byte address of the requested instruction.
REQ-014 Port: fetch_ready  output  1  block accepts a fetch this cycle.
REQ-015 Port: fetch_valid  output  1  instruction and fault flags are valid.
REQ-016 Port: instruction  output  DATA_W  fetched word; NOP (all zero) on fault.
REQ-017 Port: fault_misalign  output  1  fetched PC had PC[1:0] not equal to 0.
REQ-018 Port: fault_range  output  1  fetched word index was at or beyond prog_len.
REQ-019 Port: prog_len  output  $clog2(DEPTH)+1  number of words loaded by the last completed load.

Function
REQ-020 FSM states: EMPTY, LOAD, RUN; reset enters EMPTY.
REQ-021 Transitions: EMPTY->LOAD on load_start; LOAD->RUN on an accepted word with load_last, or when DEPTH words have been written; RUN->LOAD on load_start.
REQ-022 load_ready = 1 only in LOAD; a word is accepted when load_valid and load_ready are both 1; it is written at wr_ptr, then wr_ptr increments.
REQ-023 Entering LOAD clears wr_ptr to 0; prog_len keeps its old value until load_done.
REQ-024 load_done pulses the cycle after the completing word is accepted; prog_len = wr_ptr+1 in the same cycle.
REQ-025 Once DEPTH words are written, the load completes even if load_last is 0; prog_len = DEPTH.
REQ-026 load_start while in LOAD restarts the load: wr_ptr = 0, and any load word presented in that cycle is discarded.
REQ-027 fetch_ready = 1 only in RUN; a fetch is accepted when fetch_req and fetch_ready are both 1.
REQ-028 Word index = PC[$clog2(DEPTH)+1:2]; PC bits above that range count as out of range.
REQ-029 Read latency is 1 cycle: fetch_valid, instruction and the fault flags are registered; one fetch per cycle, back to back.
REQ-030 When a fault occurs, instruction = 0 and the memory contents are unchanged.
REQ-031 Both faults can assert together.
REQ-032 fetch_valid is 0 in any cycle that follows a cycle with no accepted fetch.
REQ-033 A fetch and a load_start in the same cycle: the fetch is accepted and its data returned; the FSM moves to LOAD.
REQ-034 Memory contents are not cleared by reset or by load_start; words beyond prog_len are not guaranteed.

Reset
REQ-035 On reset, state = EMPTY, wr_ptr = 0 and prog_len = 0.
REQ-036 On reset, all outputs = 0: load_ready, load_done, fetch_ready, fetch_valid, instruction and both fault flags.
REQ-037 Reset during LOAD abandons the load; prog_len = 0 and no load_done pulse is produced.
REQ-038 The memory array has no reset.

Structure
REQ-039 Shared package mips_pkg holds: the FSM state enum imem_state_t, the NOP constant (32'b0) and the word-offset constant (2).
REQ-040 One sub-module, imem_ram: single-port write, registered read, DEPTH x DATA_W, inferable as block RAM.
REQ-041 The FSM, pointers and fault logic live in instr_mem_loader.

Verification
REQ-042 Reset, then load 6 words (addi 0x20110001 ... 0x20080003) with load_last on word 6 -> load_done pulses once, prog_len = 6, state = RUN.
REQ-043 Fetches at PC 0, 4, 8 on consecutive cycles -> fetch_valid is 1 on the next three cycles with words 0, 1, 2; no faults.
REQ-044 Fetch at PC = 6 -> fault_misalign = 1, instruction = 0; fetch at PC = 24 with prog_len = 6 -> fault_range = 1.
REQ-045 Stream DEPTH words with load_last never asserted -> load auto-completes with prog_len = DEPTH; fetch at PC = 4*(DEPTH-1) returns the last word.
REQ-046 Assert reset in the middle of a load (after word 3) -> state = EMPTY, prog_len = 0, fetch_ready = 0, no load_done.
REQ-047 load_start in the same cycle as a fetch in RUN -> the fetch data is returned next cycle, load_ready = 1, and a fetch on the following cycle is refused (fetch_ready = 0).
